// File: rtl/video_in_pkg.sv
// video_in_pkg: shared defaults and capture state encoding
// for the video-in pack and store stages.
package video_in_pkg;

   localparam int DEF_WIDTH      = 640;
   localparam int DEF_HEIGHT     = 480;
   localparam int DEF_NB_PACK    = 16;
   localparam int DEF_FIFO_DEPTH = 64;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SOF,
      CAPTURE,
      DONE
   } pack_state_t;

endpackage

// File: rtl/video_in_pack_if.sv
// video_in_pack_if: camera pixel stream in, packed word stream out
// towards the video-in RAM store stage.
interface video_in_pack_if;
   import video_in_pkg::*;

   logic        new_addr;
   logic [7:0]  pixel_in;
   logic        line_valid;
   logic        frame_valid;
   logic        r_ack;
   logic [31:0] data_fifo;
   logic        nb_pack_available;
   logic        overflow;
   logic        frame_done;
   pack_state_t state;

   modport master (
      output new_addr, pixel_in, line_valid, frame_valid, r_ack,
      input  data_fifo, nb_pack_available, overflow, frame_done, state
   );

   modport slave (
      input  new_addr, pixel_in, line_valid, frame_valid, r_ack,
      output data_fifo, nb_pack_available, overflow, frame_done, state
   );

endinterface

// File: rtl/video_in_fifo.sv
// video_in_fifo: synchronous first-word-fall-through FIFO.
// A push into a full FIFO only lands when a pop frees a slot.
module video_in_fifo #(
   parameter  int DEPTH = 64,
   parameter  int W     = 32,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/video_in_pack.sv
// video_in_pack: registers the camera stream, packs four pixels per
// word and queues words for the store stage; re-arms on new_addr.
module video_in_pack
   import video_in_pkg::*;
#(
   parameter int p_WIDTH       = DEF_WIDTH,
   parameter int p_HEIGHT      = DEF_HEIGHT,
   parameter int NB_PACK_STORE = DEF_NB_PACK,
   parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
   input  logic           clk,
   input  logic           RST,
   video_in_pack_if.slave bus
);

   localparam int              LW    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [19:0]     TOTAL = 20'(p_WIDTH * p_HEIGHT);
   localparam logic [LW-1:0]   THR   = LW'(NB_PACK_STORE);

   pack_state_t   state;
   pack_state_t   state_d;
   logic [7:0]    px_q;
   logic          lv_q;
   logic          fv_q;
   logic          fv_qq;
   logic [23:0]   pack;
   logic [1:0]    byte_idx;
   logic [19:0]   pix_cnt;
   logic          ovf_q;
   logic          done_q;
   logic          fv_rise;
   logic          sample;
   logic          last;
   logic          abort;
   logic          push;
   logic [LW-1:0] level;
   logic          full;
   logic          empty;
   logic [31:0]   rdata;

   assign fv_rise = fv_q & ~fv_qq;
   assign sample  = lv_q & fv_q &
                    ((state == CAPTURE) | ((state == WAIT_SOF) & fv_rise));
   assign last    = sample & ((pix_cnt + 20'd1) == TOTAL);
   assign abort   = (state == CAPTURE) & ~fv_q;
   assign push    = sample & (byte_idx == 2'd3) & ~bus.new_addr;

   video_in_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (32)
   ) u_fifo (
      .clk   (clk),
      .rst   (RST),
      .flush (bus.new_addr),
      .push  (push),
      .pop   (bus.r_ack),
      .wdata ({px_q, pack}),
      .rdata (rdata),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (RST) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:     ;
         WAIT_SOF: if (fv_rise) state_d = last ? DONE : CAPTURE;
         CAPTURE:  begin
            if (abort)     state_d = WAIT_SOF;
            else if (last) state_d = DONE;
         end
         DONE:     ;
      endcase
      if (bus.new_addr) state_d = WAIT_SOF;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         px_q     <= '0;
         lv_q     <= 1'b0;
         fv_q     <= 1'b1;
         fv_qq    <= 1'b1;
         pack     <= '0;
         byte_idx <= '0;
         pix_cnt  <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         px_q   <= bus.pixel_in;
         lv_q   <= bus.line_valid;
         fv_q   <= bus.frame_valid;
         fv_qq  <= fv_q;
         done_q <= 1'b0;
         if (bus.new_addr) begin
            pack     <= '0;
            byte_idx <= '0;
            pix_cnt  <= '0;
            ovf_q    <= 1'b0;
         end else if (abort) begin
            // partial word of a truncated frame is dropped
            pack     <= '0;
            byte_idx <= '0;
            pix_cnt  <= '0;
         end else if (sample) begin
            unique case (byte_idx)
               2'd0:    pack[7:0]   <= px_q;
               2'd1:    pack[15:8]  <= px_q;
               2'd2:    pack[23:16] <= px_q;
               default: ;
            endcase
            byte_idx <= byte_idx + 2'd1;
            pix_cnt  <= pix_cnt + 20'd1;
            done_q   <= last;
            if (push && full && !bus.r_ack) ovf_q <= 1'b1;
         end
      end
   end

   assign bus.data_fifo         = empty ? '0 : rdata;
   assign bus.nb_pack_available = (level >= THR);
   assign bus.overflow          = ovf_q;
   assign bus.frame_done        = done_q;
   assign bus.state             = state;

endmodule

// File: tb/tb_video_in_pack.sv
// tb_video_in_pack: directed scenarios with random pixels/acks,
// checked cycle by cycle against a queue-based word model.
module tb_video_in_pack;
   import video_in_pkg::*;

   localparam int W     = 32;
   localparam int H     = 16;
   localparam int NB    = 16;
   localparam int DEPTH = 64;
   localparam int TOTAL = W * H;

   logic clk = 1'b0;
   logic RST;
   always #5 clk = ~clk;

   video_in_pack_if vif();

   video_in_pack #(
      .p_WIDTH       (W),
      .p_HEIGHT      (H),
      .NB_PACK_STORE (NB),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clk (clk),
      .RST (RST),
      .bus (vif.slave)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] q[$];
   bit          m_ovf = 0;
   bit          m_fd  = 0;
   int          m_cnt = 0;
   logic [31:0] m_word = '0;
   bit          p_cap = 0;
   logic [7:0]  p_px = '0;
   int          m_pops = 0;
   int          fd_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model to the coming edge,
   // then compare all outputs shortly after the edge.
   task automatic cyc(input bit na, input bit rst, input bit fv,
                      input bit lv, input logic [7:0] px,
                      input bit ack, input bit cap);
      bit          pop;
      bit          psh;
      logic [31:0] w;
      RST             = rst;
      vif.new_addr    = na;
      vif.frame_valid = fv;
      vif.line_valid  = lv;
      vif.pixel_in    = px;
      vif.r_ack       = ack;
      m_fd = 0;
      psh  = 0;
      w    = '0;
      if (rst || na) begin
         q.delete();
         m_ovf = 0;
      end else begin
         pop = ack && (q.size() > 0);
         if (p_cap) begin
            m_word[8*(m_cnt%4) +: 8] = p_px;
            m_cnt++;
            if (m_cnt % 4 == 0) begin
               psh = 1;
               w   = m_word;
            end
         end
         if (pop) begin
            void'(q.pop_front());
            m_pops++;
         end
         if (psh) begin
            if (q.size() < DEPTH) q.push_back(w);
            else m_ovf = 1;
            m_fd = (m_cnt == TOTAL);
         end
      end
      p_cap = cap;
      p_px  = px;
      @(posedge clk);
      #1;
      chk("data_fifo", vif.data_fifo, (q.size() > 0) ? q[0] : 32'h0);
      chk("nb_pack_available", 32'(vif.nb_pack_available),
          32'(q.size() >= NB));
      chk("overflow", 32'(vif.overflow), 32'(m_ovf));
      chk("frame_done", 32'(vif.frame_done), 32'(m_fd));
      if (vif.frame_done) fd_seen++;
   endtask

   function automatic bit ack_for(input int mode);
      case (mode)
         1:       return q.size() > 0;
         2:       return (q.size() == DEPTH) && p_cap && (m_cnt % 4 == 3);
         3:       return 1'($urandom_range(0, 1));
         default: return 1'b0;
      endcase
   endfunction

   task automatic idle(input int n, input bit fv, input int mode);
      for (int i = 0; i < n; i++) cyc(0, 0, fv, 0, 8'h0, ack_for(mode), 0);
   endtask

   // cut_kind: 0 frame_valid falls, 1 new_addr, 2 RST with new_addr
   task automatic run_frame(input bit capt, input bit rnd, input int mode,
                            input int cut, input int cut_kind);
      int         k;
      logic [7:0] px;
      k = 0;
      if (capt) m_cnt = 0;
      idle(2, 0, mode);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (k == cut) begin
               if (cut_kind == 0) begin
                  idle(3, 0, mode);
               end else begin
                  idle(1, 1, mode);
                  chk("cut_state", 32'(vif.state), 32'(CAPTURE));
                  cyc(1, cut_kind == 2, 1, 0, 8'h0, 0, 0);
               end
               return;
            end
            if (rnd && k > 0 && $urandom_range(0, 7) == 0)
               cyc(0, 0, 1, 0, 8'($urandom), ack_for(mode), 0);
            px = rnd ? 8'($urandom) : 8'(k);
            cyc(0, 0, 1, 1, px, ack_for(mode), capt);
            k++;
         end
         idle(1, 1, mode);
      end
      idle(2, 0, mode);
   endtask

   task automatic drain(input int bound, output int n);
      n = 0;
      for (int i = 0; i < bound && q.size() > 0; i++) begin
         cyc(0, 0, 0, 0, 8'h0, 1, 0);
         n++;
      end
   endtask

   initial begin
      int n;
      cyc(0, 1, 0, 0, 8'h0, 0, 0);
      cyc(0, 1, 0, 0, 8'h0, 0, 0);
      chk("rst_state", 32'(vif.state), 32'(IDLE));
      chk("rst_data", vif.data_fifo, 32'h0);
      cyc(0, 0, 0, 0, 8'h0, 0, 0);
      cyc(1, 0, 0, 0, 8'h0, 0, 0);
      chk("arm_state", 32'(vif.state), 32'(WAIT_SOF));

      // ramp frame, no pops: FIFO fills and overflows
      fd_seen = 0;
      run_frame(1, 0, 0, -1, 0);
      chk("t1_first_word", vif.data_fifo, 32'h03020100);
      chk("t1_overflow", 32'(vif.overflow), 32'd1);
      chk("t1_state", 32'(vif.state), 32'(DONE));
      chk("t1_fd_pulses", 32'(fd_seen), 32'd1);

      // ramp frame, pop whenever data is present
      cyc(1, 0, 0, 0, 8'h0, 0, 0);
      fd_seen = 0;
      m_pops  = 0;
      run_frame(1, 0, 1, -1, 0);
      drain(8, n);
      chk("t2_pops", 32'(m_pops), 32'(TOTAL / 4));
      chk("t2_overflow", 32'(vif.overflow), 32'd0);
      chk("t2_fd_pulses", 32'(fd_seen), 32'd1);
      chk("t2_state", 32'(vif.state), 32'(DONE));

      // frame already running at new_addr is skipped
      idle(3, 1, 0);
      cyc(1, 0, 1, 0, 8'h0, 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1, 8'($urandom), 0, 0);
      chk("t3_wait_state", 32'(vif.state), 32'(WAIT_SOF));
      chk("t3_empty", vif.data_fifo, 32'h0);
      fd_seen = 0;
      run_frame(1, 1, 3, -1, 0);
      chk("t3_state", 32'(vif.state), 32'(DONE));
      chk("t3_fd_pulses", 32'(fd_seen), 32'd1);
      drain(DEPTH + 4, n);

      // push and pop together while full
      cyc(1, 0, 0, 0, 8'h0, 0, 0);
      run_frame(1, 1, 2, -1, 0);
      chk("t4_overflow", 32'(vif.overflow), 32'd0);
      chk("t4_nb", 32'(vif.nb_pack_available), 32'd1);
      drain(DEPTH + 4, n);
      chk("t4_drained", 32'(n), 32'(DEPTH));

      // truncated frame keeps whole words, drops the partial one
      cyc(1, 0, 0, 0, 8'h0, 0, 0);
      run_frame(1, 1, 0, 42, 0);
      chk("t5a_state", 32'(vif.state), 32'(WAIT_SOF));
      chk("t5a_words", 32'(q.size()), 32'd10);
      run_frame(1, 1, 1, -1, 0);
      chk("t5a_done", 32'(vif.state), 32'(DONE));
      drain(DEPTH + 4, n);

      // new_addr mid-frame with 10 words and byte_idx 2
      cyc(1, 0, 0, 0, 8'h0, 0, 0);
      run_frame(1, 1, 0, 42, 1);
      chk("t5_state", 32'(vif.state), 32'(WAIT_SOF));
      chk("t5_data", vif.data_fifo, 32'h0);
      chk("t5_nb", 32'(vif.nb_pack_available), 32'd0);
      chk("t5_overflow", 32'(vif.overflow), 32'd0);
      run_frame(1, 1, 3, -1, 0);
      chk("t5_refill_state", 32'(vif.state), 32'(DONE));
      drain(DEPTH + 4, n);

      // RST together with new_addr during capture
      cyc(1, 0, 0, 0, 8'h0, 0, 0);
      run_frame(1, 1, 0, 100, 2);
      chk("t6_state", 32'(vif.state), 32'(IDLE));
      chk("t6_data", vif.data_fifo, 32'h0);
      chk("t6_nb", 32'(vif.nb_pack_available), 32'd0);
      chk("t6_overflow", 32'(vif.overflow), 32'd0);
      chk("t6_fd", 32'(vif.frame_done), 32'd0);
      cyc(0, 0, 0, 0, 8'h0, 0, 0);
      chk("t6_stay_idle", 32'(vif.state), 32'(IDLE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
